fl_ckpt_ctrl: RTL and testbench
===============================

Name: fl_ckpt_ctrl

Overview:
Branch-checkpoint controller for the integer physical-register free list. It snapshots the free-list bitmap each time a branch is renamed, and keeps every live snapshot current as registers retire. On a branch mispredict it drives the free list's recover/recover_fl inputs. It sits beside the rename stage, between branch resolution (from execute) and the free list.

Parameters:
CKPT_NUM, 4, number of checkpoint slots (power of two, ≥2)
CKPT_IDX_W, $clog2(CKPT_NUM), checkpoint tag width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  rename stall; a snapshot is only captured when low
ckpt_req  in  1  a branch is being renamed this cycle; capture ckpt_fl
ckpt_fl  in  PRF_INT_SIZE  free-list bitmap after this cycle's allocation (0 = free, 1 = busy)
ckpt_ack  out  1  capture accepted this cycle (combinational)
ckpt_tag  out  CKPT_IDX_W  tag given to the branch; valid when ckpt_ack
ckpt_full  out  1  no free slot (combinational from state)
br_valid  in  1  a branch resolves this cycle
br_tag  in  CKPT_IDX_W  checkpoint tag of the resolving branch
br_mispredict  in  1  resolving branch was mispredicted
prf_retire_valid  in  COMMIT_WIDTH  per-lane retire valid
prf_retire  in  COMMIT_WIDTH x PRF_INT_INDEX_SIZE  retired physical register indices
recover  out  1  restore request to free list
recover_fl  out  PRF_INT_SIZE  bitmap to restore

Behaviour:
- State:
  - snap[CKPT_NUM] bitmaps.
  - vld[CKPT_NUM].
  - head and tail pointers (CKPT_IDX_W bits, wrap modulo CKPT_NUM).
  - rec_pend flag and rec_snap register.
- Reset values:
  - vld = 0, head = tail = 0, rec_pend = 0, rec_snap = all 1s.
  - Outputs: recover = 0, ckpt_ack = 0, ckpt_full = 0.
- retire_mask: OR of one-hot(prf_retire[i]) over lanes with prf_retire_valid[i]. Computed combinationally every cycle.
- Retire fold: every cycle, each valid snap[k] <= snap[k] & ~retire_mask.
- Allocation:
  - ckpt_full = vld[tail].
  - ckpt_ack = ckpt_req & !stall & !ckpt_full & !(br_valid & br_mispredict).
  - ckpt_tag = tail.
  - On ack: snap[tail] <= ckpt_fl & ~retire_mask, vld[tail] <= 1, tail <= tail+1.
- Correct resolve (br_valid & !br_mispredict & vld[br_tag]): vld[br_tag] <= 0.
- Mispredict (br_valid & br_mispredict & vld[br_tag]):
  - rec_snap <= snap[br_tag] & ~retire_mask; rec_pend <= 1.
  - vld cleared for br_tag and every younger slot (walking from br_tag up to tail-1, modulo CKPT_NUM).
  - tail <= br_tag.
  - A same-cycle ckpt_req is dropped (ckpt_ack = 0).
- Head advance: while head != tail and !vld[head], head <= head+1. At most one step per cycle is acceptable. The same-cycle vld-clear counts as already cleared.
- A resolve with vld[br_tag] = 0 is ignored, with no state change.
- Recover timing:
  - recover = rec_pend, asserted exactly one cycle after the mispredict.
  - recover_fl = rec_snap & ~retire_mask (combinational), because the free list drops retires in its recover cycle.
  - rec_pend clears the following cycle unless a new mispredict occurs.
  - Back-to-back mispredicts: the later one reloads rec_snap, and recover stays high.
- Resolves are processed regardless of stall. Stall only blocks capture.
- Full: when all CKPT_NUM slots are valid, ckpt_full = 1 and requests are not acked. Rename must stall on ckpt_full & ckpt_req.
- Reset mid-recover: rec_pend and all slots clear in the same edge, and recover is low on the next cycle.

Decomposition:
- Shared micro-op package: CKPT_NUM/CKPT_IDX_W defines and a ckpt_tag_t typedef, so rename, ROB and branch units share the tag width.
- Optional sub-module retire_mask_gen: COMMIT_WIDTH indices to a PRF_INT_SIZE one-hot mask. It is reused by the free list.

Test Plan:
- Reset, then 4 ckpt_req (CKPT_NUM=4, stall=0) -> tags 0,1,2,3 acked; ckpt_full=1; 5th req gives ckpt_ack=0.
- Snapshot with bit 5=1, later retire p5, then mispredict tag 0 -> next cycle recover=1 and recover_fl[5]=0.
- Tags 0..2 live; mispredict tag 1 -> vld[1], vld[2] cleared, tail=1; next ckpt_req gets tag 1.
- Same-cycle ckpt_req and mispredict -> ckpt_ack=0; retire p9 during recover cycle -> recover_fl[9]=0.
- Correct resolve of tag 0 with tag 1 still live -> head advances to 1, ckpt_full=0; resolve of an invalid tag -> no state change.
- Reset asserted while rec_pend=1 -> recover=0 and ckpt_full=0 the next cycle; first req after reset gets tag 0.

Source files
------------

// File: rtl/fl_ckpt_ctrl_pkg.sv
// Shared checkpoint-tag and physical-register-file widths used by rename, ROB,
// branch units and the free-list checkpoint controller.
package fl_ckpt_ctrl_pkg;

    localparam int CKPT_NUM           = 4;
    localparam int CKPT_IDX_W         = $clog2(CKPT_NUM);
    localparam int PRF_INT_SIZE       = 64;
    localparam int PRF_INT_INDEX_SIZE = $clog2(PRF_INT_SIZE);
    localparam int COMMIT_WIDTH       = 2;

    typedef logic [CKPT_IDX_W-1:0]   ckpt_tag_t;
    typedef logic [PRF_INT_SIZE-1:0] prf_mask_t;

endpackage

// File: rtl/fl_ckpt_ctrl_retire_mask_gen.sv
// Turns the per-lane retired physical-register indices into a one-hot OR mask.
// Purely combinational, no flow control; also used by the free list.
module retire_mask_gen #(
    parameter int LANES = 2,
    parameter int SIZE  = 64,
    parameter int IDX_W = 6
) (
    input  logic [LANES-1:0]       valid_i,
    input  logic [LANES*IDX_W-1:0] idx_i,
    output logic [SIZE-1:0]        mask_o
);

    always_comb begin
        mask_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (valid_i[i]) begin
                mask_o[idx_i[i*IDX_W +: IDX_W]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fl_ckpt_ctrl.sv
// Free-list branch checkpoints: capture acked combinationally, recover one cycle
// after a mispredict; requests are refused while full or during a mispredict.
module fl_ckpt_ctrl
    import fl_ckpt_ctrl_pkg::*;
(
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      stall,
    input  logic                                      ckpt_req,
    input  logic [PRF_INT_SIZE-1:0]                   ckpt_fl,
    output logic                                      ckpt_ack,
    output logic [CKPT_IDX_W-1:0]                     ckpt_tag,
    output logic                                      ckpt_full,
    input  logic                                      br_valid,
    input  logic [CKPT_IDX_W-1:0]                     br_tag,
    input  logic                                      br_mispredict,
    input  logic [COMMIT_WIDTH-1:0]                   prf_retire_valid,
    input  logic [COMMIT_WIDTH*PRF_INT_INDEX_SIZE-1:0] prf_retire,
    output logic                                      recover,
    output logic [PRF_INT_SIZE-1:0]                   recover_fl
);

    prf_mask_t           retire_mask;
    prf_mask_t           snap_q [CKPT_NUM];
    prf_mask_t           snap_d [CKPT_NUM];
    logic [CKPT_NUM-1:0] vld_q, vld_d;
    ckpt_tag_t           head_q, head_d;
    ckpt_tag_t           tail_q, tail_d;
    logic                rec_pend_q, rec_pend_d;
    prf_mask_t           rec_snap_q, rec_snap_d;

    logic                br_ok, br_bad;
    ckpt_tag_t           squash_span;
    ckpt_tag_t           squash_off [CKPT_NUM];
    logic [CKPT_NUM-1:0] squash_sel;

    retire_mask_gen #(
        .LANES (COMMIT_WIDTH),
        .SIZE  (PRF_INT_SIZE),
        .IDX_W (PRF_INT_INDEX_SIZE)
    ) u_retire_mask_gen (
        .valid_i (prf_retire_valid),
        .idx_i   (prf_retire),
        .mask_o  (retire_mask)
    );

    assign br_ok  = br_valid & vld_q[br_tag] & ~br_mispredict;
    assign br_bad = br_valid & vld_q[br_tag] & br_mispredict;

    // Span is the distance from br_tag to the youngest slot minus one; when the
    // ring is full tail==br_tag wraps to CKPT_NUM-1, squashing every slot.
    assign squash_span = tail_q - br_tag - CKPT_IDX_W'(1);

    always_comb begin
        squash_sel = '0;
        for (int k = 0; k < CKPT_NUM; k++) begin
            squash_off[k] = CKPT_IDX_W'(k) - br_tag;
            squash_sel[k] = br_bad && (squash_off[k] <= squash_span);
        end
    end

    assign ckpt_full = vld_q[tail_q];
    assign ckpt_ack  = ckpt_req & ~stall & ~ckpt_full & ~(br_valid & br_mispredict);
    assign ckpt_tag  = tail_q;

    // The free list also drops this cycle's retires while recovering.
    assign recover    = rec_pend_q;
    assign recover_fl = rec_snap_q & ~retire_mask;

    always_comb begin
        vld_d      = vld_q;
        tail_d     = tail_q;
        head_d     = head_q;
        rec_pend_d = 1'b0;
        rec_snap_d = rec_snap_q;
        for (int k = 0; k < CKPT_NUM; k++) begin
            snap_d[k] = vld_q[k] ? (snap_q[k] & ~retire_mask) : snap_q[k];
        end

        if (br_ok) begin
            vld_d[br_tag] = 1'b0;
        end
        if (br_bad) begin
            vld_d      = vld_q & ~squash_sel;
            tail_d     = br_tag;
            rec_pend_d = 1'b1;
            rec_snap_d = snap_q[br_tag] & ~retire_mask;
        end
        if (ckpt_ack) begin
            vld_d[tail_q]  = 1'b1;
            snap_d[tail_q] = ckpt_fl & ~retire_mask;
            tail_d         = tail_q + CKPT_IDX_W'(1);
        end

        // head==tail with live slots only occurs when the ring was full.
        if (!vld_d[head_q] && ((head_q != tail_d) || (|vld_d))) begin
            head_d = head_q + CKPT_IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            rec_pend_q <= 1'b0;
            rec_snap_q <= '1;
        end else begin
            vld_q      <= vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            rec_pend_q <= rec_pend_d;
            rec_snap_q <= rec_snap_d;
        end
        snap_q <= snap_d;
    end

endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// Bench for fl_ckpt_ctrl: directed vector table, then random traffic against
// an ordered-list model of live checkpoints.
module tb_fl_ckpt_ctrl;
    import fl_ckpt_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset, stall, ckpt_req;
    logic [63:0] ckpt_fl;
    logic        ckpt_ack;
    logic [1:0]  ckpt_tag;
    logic        ckpt_full;
    logic        br_valid;
    logic [1:0]  br_tag;
    logic        br_mispredict;
    logic [1:0]  prf_retire_valid;
    logic [11:0] prf_retire;
    logic        recover;
    logic [63:0] recover_fl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    fl_ckpt_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .ckpt_req         (ckpt_req),
        .ckpt_fl          (ckpt_fl),
        .ckpt_ack         (ckpt_ack),
        .ckpt_tag         (ckpt_tag),
        .ckpt_full        (ckpt_full),
        .br_valid         (br_valid),
        .br_tag           (br_tag),
        .br_mispredict    (br_mispredict),
        .prf_retire_valid (prf_retire_valid),
        .prf_retire       (prf_retire),
        .recover          (recover),
        .recover_fl       (recover_fl)
    );

    typedef struct {
        logic        rst, st, rq;
        logic [63:0] fl;
        logic        bv;
        logic [1:0]  bt;
        logic        bm;
        logic [1:0]  rv;
        logic [5:0]  r0, r1;
        logic        e_ack;
        logic [1:0]  e_tag;
        logic        e_full, e_rec;
        int          bidx;
        logic        bval;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic rst, input logic st, input logic rq,
                                input logic [63:0] fl, input logic bv, input logic [1:0] bt,
                                input logic bm, input logic [1:0] rv, input logic [5:0] r0,
                                input logic [5:0] r1, input logic e_ack, input logic [1:0] e_tag,
                                input logic e_full, input logic e_rec, input int bidx,
                                input logic bval);
        vec_t v;
        v.rst = rst; v.st = st; v.rq = rq; v.fl = fl; v.bv = bv; v.bt = bt; v.bm = bm;
        v.rv = rv; v.r0 = r0; v.r1 = r1; v.e_ack = e_ack; v.e_tag = e_tag;
        v.e_full = e_full; v.e_rec = e_rec; v.bidx = bidx; v.bval = bval;
        vt.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic st, input logic rq, input logic [63:0] fl,
                         input logic bv, input logic [1:0] bt, input logic bm,
                         input logic [1:0] rv, input logic [5:0] r0, input logic [5:0] r1);
        reset            = rst;
        stall            = st;
        ckpt_req         = rq;
        ckpt_fl          = fl;
        br_valid         = bv;
        br_tag           = bt;
        br_mispredict    = bm;
        prf_retire_valid = rv;
        prf_retire       = {r1, r0};
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: live checkpoints in allocation order (oldest first).
    int          q_tag[$];
    logic [63:0] q_snap[$];
    int          m_tail;
    bit          m_pend;
    logic [63:0] m_rsnap;

    initial begin
        logic        r_rst, r_st, r_rq, r_bv, r_bm;
        logic [63:0] r_fl, rm;
        logic [1:0]  r_bt, r_rv;
        logic [5:0]  r_r0, r_r1;
        logic        e_full, e_ack;
        int          idx;
        bit          pend_n;

        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 2'd0, 1'b0, 2'd0, 6'd0, 6'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);

        //   rst st rq fl          bv bt bm rv r0 r1   ack tag full rec  bit val
        add(0, 0, 1, 64'h20,      0, 0, 0, 0, 0, 0,   1, 0, 0, 0,    5, 1);
        add(0, 0, 1, 64'h220,     0, 0, 0, 0, 0, 0,   1, 1, 0, 0,    5, 1);
        add(0, 0, 1, 64'h40,      0, 0, 0, 0, 0, 0,   1, 2, 0, 0,    5, 1);
        add(0, 0, 1, 64'h80,      0, 0, 0, 0, 0, 0,   1, 3, 0, 0,    5, 1);
        add(0, 0, 1, 64'h0,       0, 0, 0, 0, 0, 0,   0, 0, 1, 0,    5, 1);
        add(0, 0, 0, 64'h0,       0, 0, 0, 1, 5, 0,   0, 0, 1, 0,    5, 0);
        add(0, 0, 1, 64'h0,       1, 0, 1, 0, 0, 0,   0, 0, 1, 0,    5, 1);
        add(0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 0,   0, 0, 0, 1,    5, 0);
        add(0, 0, 1, 64'h1,       0, 0, 0, 0, 0, 0,   1, 0, 0, 0,    5, 0);
        add(0, 0, 1, 64'h202,     0, 0, 0, 0, 0, 0,   1, 1, 0, 0,    5, 0);
        add(0, 0, 1, 64'h4,       0, 0, 0, 0, 0, 0,   1, 2, 0, 0,    5, 0);
        add(0, 0, 1, 64'h0,       1, 1, 1, 0, 0, 0,   0, 0, 0, 0,    5, 0);
        add(0, 0, 1, 64'h200,     0, 0, 0, 2, 0, 9,   1, 1, 0, 1,    9, 0);
        add(0, 0, 0, 64'h0,       1, 0, 0, 0, 0, 0,   0, 0, 0, 0,    1, 1);
        add(0, 0, 0, 64'h0,       1, 3, 0, 0, 0, 0,   0, 0, 0, 0,    9, 1);
        add(0, 0, 1, 64'h400,     0, 0, 0, 0, 0, 0,   1, 2, 0, 0,    1, 1);
        add(0, 0, 1, 64'h0,       0, 0, 0, 0, 0, 0,   1, 3, 0, 0,    1, 1);
        add(0, 0, 1, 64'h0,       0, 0, 0, 0, 0, 0,   1, 0, 0, 0,    1, 1);
        add(0, 0, 1, 64'h0,       0, 0, 0, 0, 0, 0,   0, 0, 1, 0,    1, 1);
        add(0, 0, 0, 64'h0,       1, 2, 1, 0, 0, 0,   0, 0, 1, 0,    1, 1);
        add(0, 0, 0, 64'h0,       1, 1, 1, 0, 0, 0,   0, 0, 0, 1,   10, 1);
        add(0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 0,   0, 0, 0, 1,   10, 0);
        add(0, 1, 1, 64'h0,       0, 0, 0, 0, 0, 0,   0, 0, 0, 0,   10, 0);
        add(0, 0, 1, 64'h800,     0, 0, 0, 0, 0, 0,   1, 1, 0, 0,   10, 0);
        add(0, 0, 0, 64'h0,       1, 1, 1, 0, 0, 0,   0, 0, 0, 0,   10, 0);
        add(1, 0, 0, 64'h0,       0, 0, 0, 0, 0, 0,   0, 0, 0, 1,   11, 1);
        add(0, 0, 1, 64'h0,       0, 0, 0, 0, 0, 0,   1, 0, 0, 0,   11, 1);
        add(0, 0, 1, 64'h0,       1, 2, 1, 0, 0, 0,   0, 0, 0, 0,    3, 1);
        add(0, 0, 0, 64'h0,       0, 0, 0, 0, 0, 0,   0, 0, 0, 0,    3, 1);

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].st, vt[i].rq, vt[i].fl, vt[i].bv, vt[i].bt, vt[i].bm,
                  vt[i].rv, vt[i].r0, vt[i].r1);
            #1;
            check($sformatf("row%0d ckpt_ack", i), 64'(ckpt_ack), 64'(vt[i].e_ack));
            if (vt[i].e_ack)
                check($sformatf("row%0d ckpt_tag", i), 64'(ckpt_tag), 64'(vt[i].e_tag));
            check($sformatf("row%0d ckpt_full", i), 64'(ckpt_full), 64'(vt[i].e_full));
            check($sformatf("row%0d recover", i), 64'(recover), 64'(vt[i].e_rec));
            check($sformatf("row%0d recover_fl[%0d]", i, vt[i].bidx),
                  64'(recover_fl[vt[i].bidx]), 64'(vt[i].bval));
            @(negedge clock);
        end

        // Random phase starts from a fresh reset so the model is in step.
        drive(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 2'd0, 1'b0, 2'd0, 6'd0, 6'd0);
        @(negedge clock);
        q_tag.delete();
        q_snap.delete();
        m_tail  = 0;
        m_pend  = 0;
        m_rsnap = '1;

        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(99) == 0);
            r_st  = ($urandom_range(4) == 0);
            r_rq  = $urandom_range(1);
            r_fl  = {$urandom(), $urandom()};
            r_bv  = ($urandom_range(9) < 3);
            r_bt  = 2'($urandom_range(3));
            r_bm  = ($urandom_range(9) < 3);
            r_rv  = 2'($urandom_range(3));
            r_r0  = 6'($urandom_range(63));
            r_r1  = 6'($urandom_range(63));
            drive(r_rst, r_st, r_rq, r_fl, r_bv, r_bt, r_bm, r_rv, r_r0, r_r1);
            #1;

            rm = '0;
            if (r_rv[0]) rm[r_r0] = 1'b1;
            if (r_rv[1]) rm[r_r1] = 1'b1;
            idx = -1;
            e_full = 1'b0;
            foreach (q_tag[i]) begin
                if (q_tag[i] == int'(r_bt)) idx = i;
                if (q_tag[i] == m_tail) e_full = 1'b1;
            end
            e_ack = r_rq && !r_st && !e_full && !(r_bv && r_bm);

            check("rnd ckpt_ack", 64'(ckpt_ack), 64'(e_ack));
            if (e_ack) check("rnd ckpt_tag", 64'(ckpt_tag), 64'(m_tail));
            check("rnd ckpt_full", 64'(ckpt_full), 64'(e_full));
            check("rnd recover", 64'(recover), 64'(m_pend));
            check("rnd recover_fl", recover_fl, m_rsnap & ~rm);

            if (r_rst) begin
                q_tag.delete();
                q_snap.delete();
                m_tail  = 0;
                m_pend  = 0;
                m_rsnap = '1;
            end else begin
                foreach (q_snap[i]) q_snap[i] = q_snap[i] & ~rm;
                pend_n = 0;
                if (r_bv && idx >= 0) begin
                    if (r_bm) begin
                        m_rsnap = q_snap[idx];
                        pend_n  = 1;
                        m_tail  = int'(r_bt);
                        while (q_tag.size() > idx) begin
                            void'(q_tag.pop_back());
                            void'(q_snap.pop_back());
                        end
                    end else begin
                        q_tag.delete(idx);
                        q_snap.delete(idx);
                    end
                end
                if (e_ack) begin
                    q_tag.push_back(m_tail);
                    q_snap.push_back(r_fl & ~rm);
                    m_tail = (m_tail + 1) % 4;
                end
                m_pend = pend_n;
            end
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
